// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memories.
interface multicycle_ctrl_if #(
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
);
  logic [INSTR_WIDTH-1:0]  instruction;
  logic                    imem_ready;
  logic                    dmem_ready;
  logic                    imem_req;
  logic                    pc_en;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    regfile_write_enable;
  logic                    sel_bw_imm_rs2;
  logic                    dmem_read_en;
  logic                    wr_back_sel;
  logic [2:0]              state;
  logic                    illegal_instr;
  logic                    mem_timeout;
  logic [31:0]             retire_count;

  modport master (
    output instruction, imem_ready, dmem_ready,
    input  imem_req, pc_en, alu_op, regfile_write_enable, sel_bw_imm_rs2,
           dmem_read_en, wr_back_sel, state, illegal_instr, mem_timeout, retire_count
  );

  modport slave (
    input  instruction, imem_ready, dmem_ready,
    output imem_req, pc_en, alu_op, regfile_write_enable, sel_bw_imm_rs2,
           dmem_read_en, wr_back_sel, state, illegal_instr, mem_timeout, retire_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for R, I-ALU and load instructions.
// Every output is registered and computed for the state being entered.
module multicycle_ctrl #(
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  multicycle_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                  r_state;
  logic [INSTR_WIDTH-1:0]  r_ir;
  logic [7:0]              r_wait;
  logic                    r_imem_req;
  logic                    r_pc_en;
  logic                    r_rf_we;
  logic                    r_dmem_rd;
  logic [ALU_OP_WIDTH-1:0] r_alu_op;
  logic                    r_sel_rs2;
  logic                    r_wb_alu;
  logic                    r_illegal;
  logic                    r_timeout;
  logic [31:0]             r_retire_count;

  logic [6:0]              w_opcode;
  logic [2:0]              w_funct3;
  logic                    w_alt;
  logic                    w_is_r;
  logic                    w_is_i;
  logic                    w_is_ld;
  logic                    w_legal;
  logic [ALU_OP_WIDTH-1:0] w_alu_op;
  logic                    w_unused_ir;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_alt       = (r_ir[31:25] == F7_ALT);
  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_i      = (w_opcode == OP_I);
  assign w_is_ld     = (w_opcode == OP_LD);
  assign w_legal     = w_is_r | w_is_i | w_is_ld;
  assign w_unused_ir = ^r_ir;

  // ALU select from the latched IR; loads always add the address offset
  always_comb begin
    w_alu_op = '0;
    if (!w_is_ld) begin
      case (w_funct3)
        3'b000: w_alu_op = (w_is_r && w_alt) ? ALU_OP_WIDTH'(1) : ALU_OP_WIDTH'(0);
        3'b001: w_alu_op = ALU_OP_WIDTH'(2);
        3'b010: w_alu_op = ALU_OP_WIDTH'(3);
        3'b011: w_alu_op = ALU_OP_WIDTH'(4);
        3'b100: w_alu_op = ALU_OP_WIDTH'(5);
        3'b101: w_alu_op = w_alt ? ALU_OP_WIDTH'(7) : ALU_OP_WIDTH'(6);
        3'b110: w_alu_op = ALU_OP_WIDTH'(8);
        3'b111: w_alu_op = ALU_OP_WIDTH'(9);
        default: w_alu_op = '0;
      endcase
    end
  end

  // State register and next-state outputs; strobes default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_FETCH;
      r_ir           <= '0;
      r_wait         <= '0;
      r_imem_req     <= 1'b0;
      r_pc_en        <= 1'b0;
      r_rf_we        <= 1'b0;
      r_dmem_rd      <= 1'b0;
      r_alu_op       <= '0;
      r_sel_rs2      <= 1'b1;
      r_wb_alu       <= 1'b1;
      r_illegal      <= 1'b0;
      r_timeout      <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_imem_req <= 1'b0;
      r_pc_en    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_dmem_rd  <= 1'b0;
      r_alu_op   <= '0;
      r_sel_rs2  <= 1'b1;
      r_wb_alu   <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (io_bus.imem_ready) begin
            r_ir    <= io_bus.instruction;
            r_state <= S_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state   <= S_EXEC;
            r_alu_op  <= w_alu_op;
            r_sel_rs2 <= w_is_r;
            r_wb_alu  <= !w_is_ld;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end
        end
        S_EXEC: begin
          r_alu_op  <= w_alu_op;
          r_sel_rs2 <= w_is_r;
          r_wb_alu  <= !w_is_ld;
          r_wait    <= '0;
          if (w_is_ld) begin
            r_state   <= S_MEM;
            r_dmem_rd <= 1'b1;
          end else begin
            r_state <= S_WB;
            r_rf_we <= 1'b1;
            r_pc_en <= 1'b1;
          end
        end
        S_MEM: begin
          if (io_bus.dmem_ready) begin
            r_state   <= S_WB;
            r_rf_we   <= 1'b1;
            r_pc_en   <= 1'b1;
            r_alu_op  <= w_alu_op;
            r_sel_rs2 <= w_is_r;
            r_wb_alu  <= !w_is_ld;
            r_wait    <= '0;
          end else if (r_wait == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_HALT;
            r_wait    <= '0;
          end else begin
            r_dmem_rd <= 1'b1;
            r_alu_op  <= w_alu_op;
            r_sel_rs2 <= w_is_r;
            r_wb_alu  <= !w_is_ld;
            r_wait    <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_retire_count <= r_retire_count + 32'd1;
          r_imem_req     <= 1'b1;
          r_state        <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign io_bus.imem_req             = r_imem_req;
  assign io_bus.pc_en                = r_pc_en;
  assign io_bus.alu_op               = r_alu_op;
  assign io_bus.regfile_write_enable = r_rf_we;
  assign io_bus.sel_bw_imm_rs2       = r_sel_rs2;
  assign io_bus.dmem_read_en         = r_dmem_rd;
  assign io_bus.wr_back_sel          = r_wb_alu;
  assign io_bus.state                = r_state;
  assign io_bus.illegal_instr        = r_illegal;
  assign io_bus.mem_timeout          = r_timeout;
  assign io_bus.retire_count         = r_retire_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: randomized instruction stream against a
// per-instruction outcome model, with a decoupled cycle monitor.
module tb_multicycle_ctrl;

  localparam int MEM_TO  = 15;
  localparam int BUDGET  = 100;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  typedef struct {
    bit          is_halt;
    bit          ill;
    bit          tmo;
    int          alu;
    bit          sel;
    bit          wbs;
    int          mem;
    int          lat;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4)) bus ();

  multicycle_ctrl #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus)
  );

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] p_instr = '0;
  int          p_delay = 0;
  int          issued = 0;
  int          taken = 0;
  logic [31:0] model_cnt = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Outcome of one instruction from the ISA rules, independent of cycle behaviour
  function automatic exp_t model(input logic [31:0] ins, input int delay, input logic [31:0] cnt_now);
    exp_t e;
    int tbl[8];
    logic [6:0] op;
    int f3;
    bit alt;
    tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    op  = ins[6:0];
    f3  = int'(ins[14:12]);
    alt = (ins[31:25] == 7'b0100000);
    e = '{default: 0};
    e.sel = 1; e.wbs = 1; e.cnt = cnt_now + 32'd1;
    if (op == 7'h33 || op == 7'h13) begin
      e.alu = tbl[f3] + ((alt && (f3 == 5 || (f3 == 0 && op == 7'h33))) ? 1 : 0);
      e.sel = (op == 7'h33);
      e.lat = 4;
    end else if (op == 7'h03) begin
      e.sel = 0; e.wbs = 0;
      if (delay < MEM_TO) begin
        e.mem = delay + 1;
        e.lat = 4 + e.mem;
      end else begin
        e.is_halt = 1; e.tmo = 1; e.mem = MEM_TO; e.cnt = cnt_now;
      end
    end else begin
      e.is_halt = 1; e.ill = 1; e.cnt = cnt_now;
    end
    return e;
  endfunction

  // Memory responder: serves pending fetches, delays data, injects ignored noise
  int r_delay = 0;
  int mcnt = 0;
  always @(negedge clk) begin
    if (rst_n && bus.state == S_FETCH && bus.imem_req && taken != issued) begin
      bus.instruction = p_instr;
      bus.imem_ready  = 1'b1;
      r_delay = p_delay;
      mcnt = 0;
      taken++;
    end else begin
      bus.instruction = $urandom;
      bus.imem_ready  = (bus.state != S_FETCH) ? 1'($urandom % 2) : 1'b0;
    end
    if (bus.state == S_MEM) begin
      bus.dmem_ready = (mcnt == r_delay);
      mcnt++;
    end else begin
      bus.dmem_ready = 1'($urandom % 2);
    end
  end

  // Monitor: per-cycle invariants plus pop-and-compare at WB and HALT entry
  logic [2:0]  prev_st = S_FETCH;
  bit          m_active = 0;
  int          m_lat = 0;
  int          m_mem = 0;
  bit          m_cnt_chk = 0;
  logic [31:0] m_cnt_exp = '0;
  bit          m_hill = 0;
  bit          m_htmo = 0;
  always @(negedge clk) begin
    exp_t cur;
    logic [2:0] st;
    if (!rst_n) begin
      m_active = 0; m_lat = 0; m_mem = 0; m_cnt_chk = 0; prev_st = S_FETCH;
    end else begin
      st = bus.state;
      if (m_cnt_chk) begin
        check("retire_count", bus.retire_count, m_cnt_exp);
        m_cnt_chk = 0;
      end
      if (st == S_DECODE && prev_st == S_FETCH) begin
        m_active = 1; m_lat = 1; m_mem = 0;
      end
      if (m_active) m_lat++;
      if (st == S_MEM) m_mem++;
      check("dmem_read_en", bus.dmem_read_en, (st == S_MEM));
      if (st == S_EXEC || st == S_MEM || st == S_WB) begin
        if (q.size() > 0) begin
          cur = q[0];
          check("alu_op", bus.alu_op, cur.alu);
          check("sel_bw_imm_rs2", bus.sel_bw_imm_rs2, cur.sel);
          check("wr_back_sel", bus.wr_back_sel, cur.wbs);
        end
      end else begin
        check("alu_op idle", bus.alu_op, 0);
      end
      if (st == S_WB) begin
        check("wb strobes", {bus.regfile_write_enable, bus.pc_en}, 2'b11);
        if (q.size() == 0) check("unexpected retire", 1, 0);
        else begin
          cur = q.pop_front();
          check("retire expected", cur.is_halt, 0);
          check("latency", m_lat, cur.lat);
          check("mem cycles", m_mem, cur.mem);
          m_cnt_exp = cur.cnt;
          m_cnt_chk = 1;
        end
        m_active = 0;
      end else begin
        check("strobes low", {bus.regfile_write_enable, bus.pc_en}, 2'b00);
      end
      if (st == S_HALT) begin
        if (prev_st != S_HALT) begin
          if (q.size() == 0) check("unexpected halt", 1, 0);
          else begin
            cur = q.pop_front();
            check("halt expected", cur.is_halt, 1);
            check("halt mem cycles", m_mem, cur.mem);
            m_hill = cur.ill; m_htmo = cur.tmo;
          end
          m_active = 0;
        end
        check("halt flags", {bus.illegal_instr, bus.mem_timeout}, {m_hill, m_htmo});
        check("halt imem_req", bus.imem_req, 0);
      end else begin
        check("flags clear", {bus.illegal_instr, bus.mem_timeout}, 2'b00);
      end
      if (st == S_FETCH) check("fetch imem_req", bus.imem_req, 1);
      prev_st = st;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || taken != issued) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drain timeout", (n >= BUDGET), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input int delay, input bit do_wait);
    exp_t e;
    e = model(ins, delay, model_cnt);
    if (!e.is_halt) model_cnt = model_cnt + 32'd1;
    q.push_back(e);
    p_instr = ins;
    p_delay = delay;
    issued++;
    if (do_wait) wait_done();
  endtask

  task automatic chk_reset_vals();
    check("rst state", bus.state, S_FETCH);
    check("rst imem_req", bus.imem_req, 0);
    check("rst pc_en", bus.pc_en, 0);
    check("rst rf_we", bus.regfile_write_enable, 0);
    check("rst dmem_read_en", bus.dmem_read_en, 0);
    check("rst alu_op", bus.alu_op, 0);
    check("rst illegal", bus.illegal_instr, 0);
    check("rst timeout", bus.mem_timeout, 0);
    check("rst retire_count", bus.retire_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    q.delete();
    model_cnt = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    int cat;
    int n;
    #1 chk_reset_vals();
    #11 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'h40B5_0533, 0, 1);
    issue(32'h0045_2283, 3, 1);
    issue(32'h4030_D093, 0, 1);
    issue(32'h0030_D093, 0, 1);

    for (int i = 0; i < 40; i++) begin
      cat = int'($urandom_range(0, 2));
      ins = $urandom;
      case (cat)
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        default: ins[6:0] = 7'h03;
      endcase
      if ($urandom % 2 == 1) ins[31:25] = ($urandom % 2 == 1) ? 7'h20 : 7'h00;
      issue(ins, int'($urandom_range(0, 5)), 1);
    end

    issue(32'h0045_2283, MEM_TO - 1, 1);

    @(negedge clk);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1 release dut.r_retire_count;
    model_cnt = 32'hFFFF_FFFF;
    issue(32'h40B5_0533, 0, 1);

    issue(32'h0000_0063, 0, 1);
    repeat (8) @(negedge clk);
    do_reset();

    issue(32'h0045_2283, 255, 1);
    repeat (4) @(negedge clk);
    do_reset();

    issue(32'h0045_2283, 255, 0);
    n = 0;
    while (bus.state != S_MEM && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach MEM", (n < 50), 1);
    repeat (3) @(negedge clk);
    do_reset();

    issue(32'h0030_D093, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
